hazard_control: RTL and testbench
=================================

HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, data-memory read latency in cycles (legal range 1..16).
REQ-002 SHALL have one clock and synchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: if_id_rs  in  5  rs of the instruction in ID; if_id_rt  in  5  rt of the instruction in ID; if_id_uses_rt  in  1  ID instruction reads rt.
REQ-004 SHALL have ports: id_ex_memread  in  1  EX instruction is a load; id_ex_rt  in  5  load destination in EX; ex_mem_memread  in  1  MEM instruction is a load; pcsrc  in  1  branch taken, resolved in MEM.
REQ-005 SHALL have 1-bit outputs: pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write (register hold enables); id_ex_bubble (zero ID/EX control); flush_if_id, flush_id_ex, flush_ex_mem.
REQ-006 SHALL have 16-bit outputs: stall_cnt (load-use stalls), flush_cnt (taken-branch flushes), freeze_cnt (memory-wait cycles).

Function
REQ-007 SHALL implement a 2-state FSM, RUN and WAIT, with a 4-bit wait counter wcnt.
REQ-008 SHALL assert freeze combinationally when (state==RUN and ex_mem_memread and MEM_LAT>1) or (state==WAIT and wcnt!=0).
REQ-009 SHALL transition RUN->WAIT with wcnt=MEM_LAT-2 on the freeze condition in RUN, decrement wcnt in WAIT while wcnt!=0, and go WAIT->RUN when wcnt==0.
REQ-010 SHALL drive all five write enables to 0 when freeze=1 and to 1 otherwise, except as REQ-012 specifies.
REQ-011 SHALL define loaduse = id_ex_memread and id_ex_rt!=0 and (id_ex_rt==if_id_rs or (if_id_uses_rt and id_ex_rt==if_id_rt)).
REQ-012 SHALL, when loaduse=1 and freeze=0 and pcsrc=0, set pc_write=0, if_id_write=0 and id_ex_bubble=1, with the remaining write enables at 1, for exactly one cycle per load.
REQ-013 SHALL, when pcsrc=1 and freeze=0, assert flush_if_id, flush_id_ex and flush_ex_mem in the same cycle and suppress load-use stalling (pcsrc outranks loaduse).
REQ-014 SHALL give priority freeze > pcsrc flush > load-use stall; under freeze, flush and bubble outputs SHALL be 0.
REQ-015 SHALL never freeze and never enter WAIT when MEM_LAT==1, so a load in MEM causes zero extra cycles.
REQ-016 SHALL re-evaluate a new load reaching MEM on the cycle after WAIT exits, which allows back-to-back loads to each incur MEM_LAT-1 freeze cycles.
REQ-017 SHALL increment stall_cnt on each REQ-012 cycle, flush_cnt on each REQ-013 cycle and freeze_cnt on each freeze cycle, each saturating at 16'hFFFF.

Reset
REQ-018 SHALL on rst=1 at a clock edge set state=RUN, wcnt=0 and all counters to 0, including a reset that arrives mid-WAIT.
REQ-019 SHALL, while rst=1, drive all write enables to 1 and id_ex_bubble and all flushes to 0, regardless of other inputs.

Structure
REQ-020 SHALL place the state encoding (RUN=0, WAIT=1) and counter width 16 in the shared pipeline package, alongside the MEM_LAT default.
REQ-021 SHALL instantiate one sub-module, sat_counter16, three times for the counters; all other logic SHALL be flat and instantiated once in the pipeline top.

Verification
REQ-022 SHALL cover load-use: id_ex_memread=1, id_ex_rt=5, if_id_rs=5 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt becomes 1.
REQ-023 SHALL cover the $zero exemption: id_ex_rt=0, if_id_rs=0, id_ex_memread=1 -> no stall, all enables 1.
REQ-024 SHALL cover MEM_LAT=3 with ex_mem_memread=1 for one RUN cycle -> freeze for 2 cycles (all enables 0), then release; freeze_cnt=2.
REQ-025 SHALL cover a simultaneous event: pcsrc=1 and loaduse=1 together -> three flushes asserted, id_ex_bubble=0; flush_cnt=1, stall_cnt unchanged.
REQ-026 SHALL cover reset mid-WAIT: MEM_LAT=4, rst=1 on the second freeze cycle -> next cycle state RUN, enables 1, counters 0.
REQ-027 SHALL cover saturation: drive 65,536 load-use stalls -> stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_control_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_control_pkg : shared pipeline constants and FSM state encoding |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package hazard_control_pkg;

   localparam int c_cnt_w           = 16;
   localparam int c_mem_lat_default = 1;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      WAIT = 1'b1
   } state_e;

endpackage
`default_nettype wire

// File: rtl/sat_counter16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter16 : event counter that sticks at its all-ones value       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sat_counter16
   import hazard_control_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               inc,
   output logic [c_cnt_w-1:0] count
);

   logic [c_cnt_w-1:0] count_q;
   logic [c_cnt_w-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {c_cnt_w{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_control : load-use stall, branch flush and memory-wait freeze  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hazard_control
   import hazard_control_pkg::*;
#(
   parameter int MEM_LAT = c_mem_lat_default
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [4:0]         if_id_rs,
   input  logic [4:0]         if_id_rt,
   input  logic               if_id_uses_rt,
   input  logic               id_ex_memread,
   input  logic [4:0]         id_ex_rt,
   input  logic               ex_mem_memread,
   input  logic               pcsrc,
   output logic               pc_write,
   output logic               if_id_write,
   output logic               id_ex_write,
   output logic               ex_mem_write,
   output logic               mem_wb_write,
   output logic               id_ex_bubble,
   output logic               flush_if_id,
   output logic               flush_id_ex,
   output logic               flush_ex_mem,
   output logic [c_cnt_w-1:0] stall_cnt,
   output logic [c_cnt_w-1:0] flush_cnt,
   output logic [c_cnt_w-1:0] freeze_cnt
);

   localparam logic       c_lat_gt1   = (MEM_LAT > 1);
   localparam logic [3:0] c_wait_init = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

   state_e     state_q, state_d;
   logic [3:0] wcnt_q, wcnt_d;
   logic       freeze, loaduse;
   logic       stall_ev, flush_ev, freeze_ev;

   always_comb begin
      freeze  = ((state_q == RUN) && ex_mem_memread && c_lat_gt1) ||
                ((state_q == WAIT) && (wcnt_q != 4'd0));
      loaduse = id_ex_memread && (id_ex_rt != 5'd0) &&
                ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         RUN: begin
            if (freeze) begin
               state_d = WAIT;
               wcnt_d  = c_wait_init;
            end
         end
         WAIT: begin
            if (wcnt_q != 4'd0) begin
               wcnt_d = wcnt_q - 4'd1;
            end else begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Priority: reset override, then freeze, then branch flush, then load-use.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
      id_ex_bubble = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_ex_mem = 1'b0;
      stall_ev     = 1'b0;
      flush_ev     = 1'b0;
      freeze_ev    = 1'b0;
      if (!rst) begin
         if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            freeze_ev    = 1'b1;
         end else if (pcsrc) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            flush_ev     = 1'b1;
         end else if (loaduse) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall_ev     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         wcnt_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   sat_counter16 u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_ev),
      .count (stall_cnt)
   );

   sat_counter16 u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_ev),
      .count (flush_cnt)
   );

   sat_counter16 u_freeze_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (freeze_ev),
      .count (freeze_cnt)
   );

endmodule
`default_nettype wire

// File: tb/tb_hazard_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hazard_control : three latency variants against a timeline model  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_hazard_control;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
   logic       if_id_uses_rt, id_ex_memread, ex_mem_memread, pcsrc;

   // ctl bits: pc, if_id, id_ex, ex_mem, mem_wb writes, bubble, three flushes
   logic [2:0][8:0]  ctl;
   logic [2:0][15:0] st_c, fl_c, fr_c;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      hazard_control #(.MEM_LAT(g == 0 ? 1 : g + 2)) u_dut (
         .clk            (clk),
         .rst            (rst),
         .if_id_rs       (if_id_rs),
         .if_id_rt       (if_id_rt),
         .if_id_uses_rt  (if_id_uses_rt),
         .id_ex_memread  (id_ex_memread),
         .id_ex_rt       (id_ex_rt),
         .ex_mem_memread (ex_mem_memread),
         .pcsrc          (pcsrc),
         .pc_write       (ctl[g][8]),
         .if_id_write    (ctl[g][7]),
         .id_ex_write    (ctl[g][6]),
         .ex_mem_write   (ctl[g][5]),
         .mem_wb_write   (ctl[g][4]),
         .id_ex_bubble   (ctl[g][3]),
         .flush_if_id    (ctl[g][2]),
         .flush_id_ex    (ctl[g][1]),
         .flush_ex_mem   (ctl[g][0]),
         .stall_cnt      (st_c[g]),
         .flush_cnt      (fl_c[g]),
         .freeze_cnt     (fr_c[g])
      );
   end

   // Timeline model: a load entering MEM at cycle t freezes cycles t..t+L-2,
   // lets cycle t+L-1 through, and new loads are looked at from t+L on.
   int cyc = 0;
   int frz_end[3];
   int blk_end[3];
   int m_st[3], m_fl[3], m_fr[3];

   function automatic int lat(int k);
      return (k == 0) ? 1 : k + 2;
   endfunction

   function automatic bit m_trigger(int k);
      return (cyc >= blk_end[k]) && ex_mem_memread && (lat(k) > 1);
   endfunction

   function automatic bit m_freeze(int k);
      return (cyc < frz_end[k]) || m_trigger(k);
   endfunction

   function automatic bit m_loaduse();
      return id_ex_memread && (id_ex_rt != 0) &&
             ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
   endfunction

   function automatic logic [8:0] exp_ctl(int k);
      if (rst)              return 9'h1F0;
      else if (m_freeze(k)) return 9'h000;
      else if (pcsrc)       return 9'h1F7;
      else if (m_loaduse()) return 9'h078;
      else                  return 9'h1F0;
   endfunction

   function automatic void advance();
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            frz_end[k] = 0;
            blk_end[k] = 0;
            m_st[k] = 0; m_fl[k] = 0; m_fr[k] = 0;
         end else begin
            if (m_freeze(k))                 m_fr[k] = (m_fr[k] < 65535) ? m_fr[k] + 1 : m_fr[k];
            else if (pcsrc)                  m_fl[k] = (m_fl[k] < 65535) ? m_fl[k] + 1 : m_fl[k];
            else if (m_loaduse())            m_st[k] = (m_st[k] < 65535) ? m_st[k] + 1 : m_st[k];
            if (m_trigger(k)) begin
               frz_end[k] = cyc + lat(k) - 1;
               blk_end[k] = cyc + lat(k);
            end
         end
      end
      cyc++;
   endfunction

   task automatic clk_edge();
      @(posedge clk);
      advance();
      #1;
   endtask

   task automatic idle_inputs();
      rst = 1'b0; if_id_rs = 5'd1; if_id_rt = 5'd2; if_id_uses_rt = 1'b0;
      id_ex_memread = 1'b0; id_ex_rt = 5'd3; ex_mem_memread = 1'b0; pcsrc = 1'b0;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         rst = 1'b1; if_id_rs = 5'd7; if_id_rt = 5'd7; if_id_uses_rt = 1'b1;
         id_ex_memread = 1'b1; id_ex_rt = 5'd7; ex_mem_memread = 1'b1; pcsrc = c[0];
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (ctl[k] !== 9'h1F0) begin
               n_fail++;
               $display("FAIL reset_ctl inst%0d got %h exp %h", k, ctl[k], 9'h1F0);
            end
         end
         clk_edge();
      end
      idle_inputs();
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if ({st_c[k], fl_c[k], fr_c[k], ctl[k]} !== {48'd0, 9'h1F0}) begin
            n_fail++;
            $display("FAIL reset_state inst%0d got st=%0d fl=%0d fr=%0d ctl=%h exp 0 0 0 1f0",
                     k, st_c[k], fl_c[k], fr_c[k], ctl[k]);
         end
      end
      clk_edge();
   endtask

   task automatic test_load_use();
      int st0 = m_st[0];
      idle_inputs();
      id_ex_memread = 1'b1; id_ex_rt = 5'd5; if_id_rs = 5'd5;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (ctl[k] !== 9'h078) begin
            n_fail++;
            $display("FAIL load_use_ctl inst%0d got %h exp %h", k, ctl[k], 9'h078);
         end
      end
      clk_edge();
      idle_inputs();
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (ctl[k] !== 9'h1F0 || int'(st_c[k]) != st0 + 1) begin
            n_fail++;
            $display("FAIL load_use_after inst%0d got ctl=%h st=%0d exp ctl=1f0 st=%0d",
                     k, ctl[k], st_c[k], st0 + 1);
         end
      end
      clk_edge();
   endtask

   task automatic test_zero_reg();
      idle_inputs();
      id_ex_memread = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0; if_id_rt = 5'd0; if_id_uses_rt = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (ctl[k] !== 9'h1F0) begin
            n_fail++;
            $display("FAIL zero_reg inst%0d got %h exp %h", k, ctl[k], 9'h1F0);
         end
      end
      clk_edge();
      idle_inputs();
   endtask

   task automatic test_freeze();
      logic [8:0] exp_seq [3][4];
      int fr0[3];
      exp_seq[0] = '{9'h1F0, 9'h1F0, 9'h1F0, 9'h1F0};
      exp_seq[1] = '{9'h000, 9'h000, 9'h1F0, 9'h1F0};
      exp_seq[2] = '{9'h000, 9'h000, 9'h000, 9'h1F0};
      idle_inputs();
      for (int c = 0; c < 5; c++) clk_edge();
      for (int k = 0; k < 3; k++) fr0[k] = m_fr[k];
      for (int c = 0; c < 4; c++) begin
         ex_mem_memread = (c == 0);
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (ctl[k] !== exp_seq[k][c]) begin
               n_fail++;
               $display("FAIL freeze_seq inst%0d cyc%0d got %h exp %h", k, c, ctl[k], exp_seq[k][c]);
            end
         end
         if (c == 3) begin
            for (int k = 0; k < 3; k++) begin
               n_tests++;
               if (int'(fr_c[k]) != fr0[k] + lat(k) - 1) begin
                  n_fail++;
                  $display("FAIL freeze_cnt inst%0d got %0d exp %0d", k, fr_c[k], fr0[k] + lat(k) - 1);
               end
            end
         end
         clk_edge();
      end
      idle_inputs();
   endtask

   task automatic test_branch_vs_loaduse();
      int st0 = m_st[0];
      int fl0 = m_fl[0];
      idle_inputs();
      pcsrc = 1'b1; id_ex_memread = 1'b1; id_ex_rt = 5'd9; if_id_rt = 5'd9; if_id_uses_rt = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (ctl[k] !== 9'h1F7) begin
            n_fail++;
            $display("FAIL branch_ctl inst%0d got %h exp %h", k, ctl[k], 9'h1F7);
         end
      end
      clk_edge();
      idle_inputs();
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (int'(fl_c[k]) != fl0 + 1 || int'(st_c[k]) != st0) begin
            n_fail++;
            $display("FAIL branch_cnt inst%0d got fl=%0d st=%0d exp fl=%0d st=%0d",
                     k, fl_c[k], st_c[k], fl0 + 1, st0);
         end
      end
      clk_edge();
   endtask

   task automatic test_reset_mid_wait();
      idle_inputs();
      for (int c = 0; c < 5; c++) clk_edge();
      ex_mem_memread = 1'b1;
      clk_edge();
      ex_mem_memread = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if (ctl[2] !== 9'h1F0) begin
         n_fail++;
         $display("FAIL mid_wait_rst_ctl got %h exp %h", ctl[2], 9'h1F0);
      end
      clk_edge();
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({ctl[2], st_c[2], fl_c[2], fr_c[2]} !== {9'h1F0, 48'd0}) begin
         n_fail++;
         $display("FAIL mid_wait_after got ctl=%h st=%0d fl=%0d fr=%0d exp 1f0 0 0 0",
                  ctl[2], st_c[2], fl_c[2], fr_c[2]);
      end
      clk_edge();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst            = ($urandom_range(0, 39) == 0);
         if_id_rs       = 5'($urandom_range(0, 3));
         if_id_rt       = 5'($urandom_range(0, 3));
         id_ex_rt       = 5'($urandom_range(0, 3));
         if_id_uses_rt  = 1'($urandom_range(0, 1));
         id_ex_memread  = 1'($urandom_range(0, 1));
         ex_mem_memread = ($urandom_range(0, 3) == 0);
         pcsrc          = ($urandom_range(0, 3) == 0);
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (ctl[k] !== exp_ctl(k) || int'(st_c[k]) != m_st[k] ||
                int'(fl_c[k]) != m_fl[k] || int'(fr_c[k]) != m_fr[k]) begin
               n_fail++;
               $display("FAIL random cyc%0d inst%0d got ctl=%h st=%0d fl=%0d fr=%0d exp ctl=%h st=%0d fl=%0d fr=%0d",
                        c, k, ctl[k], st_c[k], fl_c[k], fr_c[k], exp_ctl(k), m_st[k], m_fl[k], m_fr[k]);
            end
         end
         clk_edge();
      end
      idle_inputs();
   endtask

   task automatic test_saturation();
      idle_inputs();
      id_ex_memread = 1'b1; id_ex_rt = 5'd4; if_id_rs = 5'd4;
      for (int c = 0; c < 65536; c++) clk_edge();
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (st_c[k] !== 16'hFFFF || m_st[k] != 65535) begin
               n_fail++;
               $display("FAIL stall_sat inst%0d pass%0d got %h exp ffff", k, r, st_c[k]);
            end
         end
         clk_edge();
      end
      idle_inputs();
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         frz_end[k] = 0; blk_end[k] = 0; m_st[k] = 0; m_fl[k] = 0; m_fr[k] = 0;
      end
      idle_inputs();
      rst = 1'b1;
      #1;
      test_reset();
      test_load_use();
      test_zero_reg();
      test_freeze();
      test_branch_vs_loaduse();
      test_reset_mid_wait();
      test_random();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
